// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Hazard-controller bundle between the pipeline datapath and the
//           stall/flush sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_memread;
  logic [4:0]       ex_wreg;
  logic             ex_branch_taken;
  logic             id_jump;
  logic             mem_access;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Datapath side: supplies hazard sources, consumes enables/flushes.
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_wreg,
           ex_branch_taken, id_jump, mem_access, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_flush, mem_err, stall_cnt, flush_cnt
  );

  // Sequencer side.
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_wreg,
           ex_branch_taken, id_jump, mem_access, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_flush, mem_err, stall_cnt, flush_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush sequencer for a 5-stage pipeline (load-use, redirect,
//           variable-latency MEM with timeout watchdog, perf counters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int            WW    = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] W_MAX = WW'(TIMEOUT - 1);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t           state;
  logic [WW-1:0]    wcnt;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic lu, mstall, tout, redirect;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;

  assign lu = bus.ex_memread && (bus.ex_wreg != 5'd0) &&
              ((bus.id_use_rs && (bus.id_rs == bus.ex_wreg)) ||
               (bus.id_use_rt && (bus.id_rt == bus.ex_wreg)));

  assign mstall = ((state == RUN) && bus.mem_access && !bus.mem_ready) ||
                  ((state == MEM_WAIT) && !bus.mem_ready && (wcnt != W_MAX));

  assign tout     = (state == MEM_WAIT) && !bus.mem_ready && (wcnt == W_MAX);
  assign redirect = bus.ex_branch_taken || bus.id_jump;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_flush = 1'b0;
    if (reset) begin
      if (mstall) begin
        mem_wb_flush = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        if (bus.ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (bus.id_jump) begin
          if_id_flush = 1'b1;
        end else if (lu) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        // The abandoned access must not retire into WB.
        mem_wb_flush = tout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      wcnt      <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.mem_access && !bus.mem_ready) begin
            state <= MEM_WAIT;
            wcnt  <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state <= RUN;
            wcnt  <= '0;
          end else if (tout) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: begin
          state <= RUN;
          wcnt  <= '0;
        end
      endcase
      if ((mstall || lu) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && !mstall && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.mem_err      = mem_err;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Resolves three hazard sources:
  - load-use hazards (ID vs EX);
  - taken branch/jump redirects;
  - variable-latency data-memory accesses in MEM, which run through a wait FSM with a timeout watchdog.
- Keeps saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 16: maximum MEM_WAIT cycles before the access is abandoned; must be ≥2.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_memread  in  1  MemRead of the instruction in EX
- ex_wreg  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch resolved taken in EX
- id_jump  in  1  j/jal/jr decoded in ID
- mem_access  in  1  MemRead|MemWrite of the instruction in MEM
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF_ID load enable
- if_id_flush  out  1  IF_ID loads a bubble
- id_ex_en  out  1  ID_EX load enable
- id_ex_flush  out  1  ID_EX loads a bubble
- ex_mem_en  out  1  EX_MEM load enable
- mem_wb_flush  out  1  MEM_WB loads a bubble
- mem_err  out  1  sticky flag: a memory access timed out
- stall_cnt  out  CNT_W  number of stalled cycles, saturating
- flush_cnt  out  CNT_W  number of redirect flushes, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT. A wait counter wcnt has width clog2(TIMEOUT)+1.
- Reset (reset==0 at a clk edge):
  - state=RUN, wcnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - While reset is low, all *_en=0 and all *_flush=0.
- Combinational terms:
  - lu = ex_memread & ex_wreg!=0 & ((id_use_rs & id_rs==ex_wreg) | (id_use_rt & id_rt==ex_wreg)).
  - mstall = (state==RUN & mem_access & !mem_ready) | (state==MEM_WAIT & !mem_ready & wcnt!=TIMEOUT-1).
  - tout = state==MEM_WAIT & !mem_ready & wcnt==TIMEOUT-1.
- Output priority, highest first:
  - mstall: freeze everything. pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_flush=1, all other flushes 0. Branch, jump and lu are ignored this cycle and are re-evaluated after release, because their inputs are held frozen.
  - ex_branch_taken: all en=1, if_id_flush=1, id_ex_flush=1.
  - id_jump: all en=1, if_id_flush=1.
  - lu: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Exactly one bubble is inserted.
  - Otherwise: all en=1, all flushes 0.
- A release cycle (mem_ready=1 in MEM_WAIT) and a tout cycle are not mstall, so the normal priority applies. On a tout cycle mem_wb_flush=1 additionally, so the abandoned access is dropped.
- FSM transitions:
  - RUN → MEM_WAIT when mem_access & !mem_ready; wcnt←1.
  - MEM_WAIT → RUN on mem_ready; wcnt←0.
  - MEM_WAIT → RUN on tout; mem_err←1; wcnt←0.
  - MEM_WAIT stays otherwise; wcnt←wcnt+1.
- Latency: mem_ready seen in the same cycle as mem_access gives zero stall cycles. The first wait cycle is the cycle the access arrives in MEM.
- mem_err is sticky and is cleared only by reset.
- Counters:
  - stall_cnt +1 every cycle with (mstall | lu), saturating at all-ones.
  - flush_cnt +1 every cycle with (ex_branch_taken | id_jump) & !mstall, saturating at all-ones.
- Reset asserted mid-MEM_WAIT: state returns to RUN on that edge and no mem_err is raised.
- Register $0 never causes a load-use stall.

Test Plan:
- lw $8 in EX (ex_memread=1, ex_wreg=8), ID add reads rs=8 → exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. The same case with ex_wreg=0 → no stall.
- ex_branch_taken=1 together with lu=1 → if_id_flush=1, id_ex_flush=1, pc_en=1 (branch wins); flush_cnt increments by 1.
- mem_access=1 with mem_ready low for 3 cycles, then high → 3 frozen cycles with all en=0 and mem_wb_flush=1. The 4th cycle releases with all en=1. stall_cnt=3; state returns to RUN.
- mem_access=1, mem_ready never asserted, TIMEOUT=16 → 15 frozen cycles. Then mem_err=1 with mem_wb_flush=1 and all en=1. State is RUN; mem_err stays 1 afterward.
- Branch taken arriving during the 2nd MEM_WAIT cycle and held until release → no flush while frozen. The flush occurs in the release cycle and flush_cnt increments exactly once.
- reset driven low in the middle of MEM_WAIT → next cycle state=RUN, counters=0, mem_err=0; outputs are all-zero while reset is low. Drive stall_cnt to all-ones → it holds at all-ones.
